sfx_player: RTL and testbench
=============================

// Module: sfx_player
// PURPOSE
//  Playback sequencer driving a synchronous sound-effect sample ROM. On trigger it walks
//  read_address 0..CLIP_LEN-1, captures each 8-bit sample after ROM latency, and presents
//  it on sample_out once per sample_tick (audio-rate strobe) toward the mixer/codec path.
// PARAMETERS
//  CLIP_LEN  17646   samples in clip (ROM depth); last address = CLIP_LEN-1
//  ADDR_W    19      width of read_address
//  ROM_LAT   1       ROM read latency in Clk cycles (address reg -> data_Out valid)
//  SILENCE   8'h80   unsigned mid-scale sample driven when not playing
// PORTS
//  Clk           in   1       system clock
//  Reset         in   1       synchronous, active-high reset
//  trigger       in   1       1-cycle pulse: start/restart playback at address 0
//  stop          in   1       1-cycle pulse: abort playback
//  sample_tick   in   1       1-cycle audio-rate strobe (same clock domain)
//  rom_data      in   8       sample from ROM data_Out
//  read_address  out  ADDR_W  registered ROM address
//  sample_out    out  8       current sample, held between ticks
//  sample_valid  out  1       1-cycle pulse when sample_out updates
//  busy          out  1       high from trigger accept until return to IDLE
//  done          out  1       1-cycle pulse after last sample emitted
//  overrun       out  1       sticky: tick arrived with one already pending; cleared by Reset/trigger
// BEHAVIOUR
//  Reset: state=IDLE, read_address=0, sample_out=SILENCE, sample_valid=0, busy=0, done=0, overrun=0.
//  States: IDLE, FETCH, WAIT, READY, FINISH.
//  IDLE: ticks ignored. trigger -> FETCH, read_address=0, busy=1.
//  FETCH: address stable 1 cycle -> WAIT; WAIT counts ROM_LAT cycles, then rom_data latched
//   into sample buffer -> READY.
//  READY: on tick (or pending tick), same edge: sample_out<=buffer, sample_valid=1;
//   if read_address==CLIP_LEN-1 -> FINISH, else read_address+1 -> FETCH.
//  FINISH: done=1 for 1 cycle, sample_out<=SILENCE, busy=0 -> IDLE.
//  Tick in FETCH/WAIT: latched as pending (one deep), serviced on READY entry (no extra delay);
//   second tick while pending sets overrun, is dropped. Tick spacing >= ROM_LAT+3 never overruns.
//  trigger while busy: restart -> FETCH addr 0, pending cleared, overrun cleared, sample_out held,
//   no done pulse. trigger+stop same cycle: trigger wins.
//  stop while busy: -> IDLE next edge, sample_out=SILENCE, no done, no sample_valid. stop in IDLE: no-op.
//  trigger same cycle as READY tick: trigger wins; that tick produces no sample_valid.
//  Reset mid-playback: identical to power-up reset values next edge.
//  read_address never exceeds CLIP_LEN-1; no wrap in one-shot mode.
// CONFIGURATION
//  SFX_LOOP_EN defined: extra input port loop_en (1 bit). At last sample with loop_en=1,
//   read_address wraps to 0 -> FETCH, no FINISH, no done, busy stays 1; loop_en=0 behaves one-shot.
//  SFX_LOOP_EN undefined: port absent; always one-shot as above.
// STRUCTURE
//  sfx_pkg: state enum sfx_state_t, SFX_SILENCE=8'h80, SFX_ADDR_W=19.
//  Single module, no sub-module; ROM instantiated as peer at top level (read_address -> ROM,
//  ROM data_Out -> rom_data). ROM_LAT counter and pending-tick flag local.
// TESTING
//  1 CLIP_LEN=4, ROM mem={10,20,30,40}, trigger, tick every 8 cycles -> sample_valid x4 with
//    10,20,30,40; done pulses once, 1 cycle after 4th valid; sample_out=80h, busy=0 after.
//  2 Tick asserted 1 cycle after trigger (in FETCH) -> first sample 10 emitted on READY entry, overrun=0.
//  3 Two ticks within FETCH/WAIT -> overrun=1 sticky; one sample emitted; next trigger clears overrun.
//  4 trigger at 3rd sample while playing -> next valid sample is 10 (addr 0), no done pulse.
//  5 stop at address 2 -> IDLE next edge, sample_out=80h, busy=0, no done; Reset mid-clip same checks.
//  6 SFX_LOOP_EN, loop_en=1, CLIP_LEN=4 -> sequence 10,20,30,40,10,20; no done; drop loop_en -> ends after 40.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect playback sequencer.
package sfx_pkg;

    localparam int         SFX_ADDR_W  = 19;
    localparam logic [7:0] SFX_SILENCE = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_READY  = 3'd3,
        ST_FINISH = 3'd4
    } sfx_state_t;

endpackage

// File: rtl/sfx_player.sv
// Sound-effect playback sequencer: walks a synchronous sample ROM and emits one sample per audio tick.
// Optional SFX_LOOP_EN adds a loop_en input that wraps the clip instead of finishing.
module sfx_player
    import sfx_pkg::*;
#(
    parameter int         CLIP_LEN = 17646,
    parameter int         ADDR_W   = SFX_ADDR_W,
    parameter int         ROM_LAT  = 1,
    parameter logic [7:0] SILENCE  = SFX_SILENCE
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              trigger,
    input  logic              stop,
    input  logic              sample_tick,
    input  logic [7:0]        rom_data,
`ifdef SFX_LOOP_EN
    input  logic              loop_en,
`endif
    output logic [ADDR_W-1:0] read_address,
    output logic [7:0]        sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int                LAT_W     = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLIP_LEN - 1);

    sfx_state_t        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic [7:0]        buffer_reg;
    logic [7:0]        sample_out_reg;
    logic              valid_reg;
    logic              done_reg;
    logic              overrun_reg;
    logic              pending_reg;
    logic              wrap_en;

`ifdef SFX_LOOP_EN
    assign wrap_en = loop_en;
`else
    assign wrap_en = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            lat_cnt_reg    <= '0;
            buffer_reg     <= SILENCE;
            sample_out_reg <= SILENCE;
            valid_reg      <= 1'b0;
            done_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
            pending_reg    <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            // Restart takes priority over stop and over a tick being serviced this cycle.
            if (trigger) begin
                state_reg   <= ST_FETCH;
                addr_reg    <= '0;
                lat_cnt_reg <= '0;
                pending_reg <= 1'b0;
                overrun_reg <= 1'b0;
            end else if (stop && (state_reg != ST_IDLE)) begin
                state_reg      <= ST_IDLE;
                sample_out_reg <= SILENCE;
                pending_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_FETCH: begin
                        if (sample_tick) begin
                            if (pending_reg) overrun_reg <= 1'b1;
                            else             pending_reg <= 1'b1;
                        end
                        lat_cnt_reg <= '0;
                        state_reg   <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (sample_tick) begin
                            if (pending_reg) overrun_reg <= 1'b1;
                            else             pending_reg <= 1'b1;
                        end
                        if (lat_cnt_reg == LAST_LAT) begin
                            buffer_reg <= rom_data;
                            state_reg  <= ST_READY;
                        end else begin
                            lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
                        end
                    end
                    ST_READY: begin
                        // A pending tick is consumed on the first READY cycle; a fresh tick on top of it is lost.
                        if (sample_tick || pending_reg) begin
                            sample_out_reg <= buffer_reg;
                            valid_reg      <= 1'b1;
                            pending_reg    <= 1'b0;
                            if (sample_tick && pending_reg) overrun_reg <= 1'b1;
                            if (addr_reg == LAST_ADDR) begin
                                if (wrap_en) begin
                                    addr_reg  <= '0;
                                    state_reg <= ST_FETCH;
                                end else begin
                                    state_reg <= ST_FINISH;
                                end
                            end else begin
                                addr_reg  <= addr_reg + ADDR_W'(1);
                                state_reg <= ST_FETCH;
                            end
                        end
                    end
                    ST_FINISH: begin
                        done_reg       <= 1'b1;
                        sample_out_reg <= SILENCE;
                        state_reg      <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign read_address = addr_reg;
    assign sample_out   = sample_out_reg;
    assign sample_valid = valid_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign done         = done_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_sfx_player.sv
// Directed bench for sfx_player with a 4-entry peer ROM {10,20,30,40}; loop test needs SFX_LOOP_EN.
module tb_sfx_player;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        trigger = 1'b0;
    logic        stop = 1'b0;
    logic        sample_tick = 1'b0;
    logic [7:0]  rom_q;
    logic [18:0] read_address;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        busy;
    logic        done;
    logic        overrun;
`ifdef SFX_LOOP_EN
    logic        loop_en = 1'b0;
`endif

    logic [7:0] rom_mem [4];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_valid_cyc = 0;
    int         base;
    int         d0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    sfx_player #(
        .CLIP_LEN(4),
        .ADDR_W  (19),
        .ROM_LAT (1),
        .SILENCE (8'h80)
    ) dut (
        .Clk         (clk),
        .Reset       (Reset),
        .trigger     (trigger),
        .stop        (stop),
        .sample_tick (sample_tick),
        .rom_data    (rom_q),
`ifdef SFX_LOOP_EN
        .loop_en     (loop_en),
`endif
        .read_address(read_address),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    initial begin
        rom_mem[0] = 8'd10;
        rom_mem[1] = 8'd20;
        rom_mem[2] = 8'd30;
        rom_mem[3] = 8'd40;
    end

    // Synchronous ROM, one cycle latency
    always @(posedge clk) rom_q <= rom_mem[read_address[1:0]];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sample_valid) begin
            got_q.push_back(sample_out);
            last_valid_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic chk_q(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] v;
        v = (idx < got_q.size()) ? 32'(got_q[idx]) : 32'hFFFF_FFFF;
        chk(tag, v, exp);
    endtask

    initial begin
        // Reset
        step();
        step();
        Reset = 1'b0;
        chk("rst_addr", 32'(read_address), 32'd0);
        chk("rst_sample", 32'(sample_out), 32'h80);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Stop in IDLE does nothing
        stop = 1'b1; step(); stop = 1'b0;
        chk("idle_stop_busy", 32'(busy), 32'd0);

        // Test 1: full clip, tick every 8 cycles
        base = got_q.size();
        d0 = done_cnt;
        trigger = 1'b1; step(); trigger = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_addr0", 32'(read_address), 32'd0);
        for (int i = 0; i < 40; i++) begin
            sample_tick = (i % 8 == 3);
            step();
        end
        sample_tick = 1'b0;
        chk("t1_count", 32'(got_q.size() - base), 32'd4);
        chk_q("t1_s0", base + 0, 32'd10);
        chk_q("t1_s1", base + 1, 32'd20);
        chk_q("t1_s2", base + 2, 32'd30);
        chk_q("t1_s3", base + 3, 32'd40);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t1_done_lag", 32'(done_cyc - last_valid_cyc), 32'd1);
        chk("t1_silence", 32'(sample_out), 32'h80);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_overrun", 32'(overrun), 32'd0);

        // Test 2: tick in FETCH is held and serviced on READY
        base = got_q.size();
        trigger = 1'b1; step(); trigger = 1'b0;
        sample_tick = 1'b1; step(); sample_tick = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t2_count", 32'(got_q.size() - base), 32'd1);
        chk_q("t2_s0", base, 32'd10);
        chk("t2_overrun", 32'(overrun), 32'd0);
        chk("t2_addr", 32'(read_address), 32'd1);

        // Test 3: two ticks before READY -> overrun, one sample
        base = got_q.size();
        trigger = 1'b1; step(); trigger = 1'b0;
        sample_tick = 1'b1; step();
        sample_tick = 1'b1; step();
        sample_tick = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t3_count", 32'(got_q.size() - base), 32'd1);
        chk_q("t3_s0", base, 32'd10);
        chk("t3_overrun", 32'(overrun), 32'd1);
        step();
        step();
        chk("t3_sticky", 32'(overrun), 32'd1);
        trigger = 1'b1; step(); trigger = 1'b0;
        chk("t3_cleared", 32'(overrun), 32'd0);

        // Tests 4/5: restart on 3rd sample tick, then stop at address 2
        base = got_q.size();
        d0 = done_cnt;
        for (int i = 0; i < 48; i++) begin
            sample_tick = (i % 8 == 3);
            trigger     = (i == 19);
            stop        = (i == 40);
            step();
            if (i == 19) begin
                chk("t4_no_valid", 32'(sample_valid), 32'd0);
                chk("t4_addr0", 32'(read_address), 32'd0);
            end
            if (i == 40) begin
                chk("t5_stop_busy", 32'(busy), 32'd0);
                chk("t5_stop_silence", 32'(sample_out), 32'h80);
            end
        end
        sample_tick = 1'b0;
        trigger     = 1'b0;
        stop        = 1'b0;
        chk("t4_count", 32'(got_q.size() - base), 32'd4);
        chk_q("t4_s0", base + 0, 32'd10);
        chk_q("t4_s1", base + 1, 32'd20);
        chk_q("t4_s2", base + 2, 32'd10);
        chk_q("t4_s3", base + 3, 32'd20);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);

        // Reset in the middle of a clip
        base = got_q.size();
        d0 = done_cnt;
        trigger = 1'b1; step(); trigger = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample_tick = (i == 3);
            step();
        end
        sample_tick = 1'b0;
        chk("t5r_sample_before", 32'(sample_out), 32'd10);
        Reset = 1'b1; step(); Reset = 1'b0;
        chk("t5r_addr", 32'(read_address), 32'd0);
        chk("t5r_sample", 32'(sample_out), 32'h80);
        chk("t5r_busy", 32'(busy), 32'd0);
        chk("t5r_valid", 32'(sample_valid), 32'd0);
        chk("t5r_overrun", 32'(overrun), 32'd0);
        step();
        chk("t5r_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef SFX_LOOP_EN
        // Test 6: looping, then drop loop_en to finish after the last sample
        base = got_q.size();
        d0 = done_cnt;
        loop_en = 1'b1;
        trigger = 1'b1; step(); trigger = 1'b0;
        for (int i = 0; i < 72; i++) begin
            sample_tick = (i % 8 == 3);
            if (i == 44) begin
                chk("t6_no_done_loop", 32'(done_cnt - d0), 32'd0);
                chk("t6_busy_loop", 32'(busy), 32'd1);
                loop_en = 1'b0;
            end
            step();
        end
        sample_tick = 1'b0;
        chk("t6_count", 32'(got_q.size() - base), 32'd8);
        chk_q("t6_s0", base + 0, 32'd10);
        chk_q("t6_s3", base + 3, 32'd40);
        chk_q("t6_s4", base + 4, 32'd10);
        chk_q("t6_s5", base + 5, 32'd20);
        chk_q("t6_s7", base + 7, 32'd40);
        chk("t6_done", 32'(done_cnt - d0), 32'd1);
        chk("t6_idle", 32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
